// File: rtl/n64adv2_dram_arbiter.sv
// n64adv2_dram_arbiter: schedules the single SDRAM command port between frame writer,
// scaler prefetch reader and auto-refresh. Define N64ADV2_DRAM_ARB_URGENT_EN for urgent-read priority.
module n64adv2_dram_arbiter #(
   parameter int REF_INTERVAL = 390,
   parameter int REF_FORCE    = 4,
   parameter int REF_MAX      = 8,
   parameter int ADDR_W       = 22
) (
   input  logic              DRAM_CLK_i,
   input  logic              DRAM_RST_i,
   input  logic              wr_req_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   output logic              wr_gnt_o,
   output logic              wr_done_o,
   input  logic              rd_req_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic              rd_gnt_o,
   output logic              rd_done_o,
   input  logic              rd_urgent_i,
   output logic              ctrl_valid_o,
   output logic [1:0]        ctrl_cmd_o,
   output logic [ADDR_W-1:0] ctrl_addr_o,
   input  logic              ctrl_ready_i,
   input  logic              ctrl_done_i,
   output logic              ref_overflow_o
);

   localparam int TICK_W = (REF_INTERVAL > 1) ? $clog2(REF_INTERVAL) : 1;
   localparam int DEBT_W = $clog2(REF_MAX + 1);
   localparam logic [1:0] CMD_RD  = 2'b00;
   localparam logic [1:0] CMD_WR  = 2'b01;
   localparam logic [1:0] CMD_REF = 2'b10;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BUSY} state_t;

   state_t            state;
   logic [TICK_W-1:0] tick_cnt;
   logic [DEBT_W-1:0] debt;
   logic [DEBT_W-1:0] debt_nxt;
   logic              rr_rd;
   logic              tick_wrap;
   logic              ref_acc;
   logic              urgent_rd;
   logic              sel_valid;
   logic [1:0]        sel_cmd;
   logic [ADDR_W-1:0] sel_addr;

   assign tick_wrap = (tick_cnt == TICK_W'(REF_INTERVAL - 1));
   assign ref_acc   = (state == ST_ISSUE) && ctrl_ready_i && (ctrl_cmd_o == CMD_REF);

`ifdef N64ADV2_DRAM_ARB_URGENT_EN
   assign urgent_rd = rd_urgent_i & rd_req_i;
`else
   assign urgent_rd = rd_urgent_i & 1'b0;
`endif

   // a tick and an accepted refresh in the same cycle cancel out
   always_comb begin
      debt_nxt = debt;
      if (tick_wrap && !ref_acc && (debt != DEBT_W'(REF_MAX)))
         debt_nxt = debt + DEBT_W'(1);
      else if (!tick_wrap && ref_acc)
         debt_nxt = debt - DEBT_W'(1);
   end

   always_comb begin
      sel_valid = 1'b1;
      sel_cmd   = CMD_REF;
      if (debt >= DEBT_W'(REF_FORCE))
         sel_cmd = CMD_REF;
      else if (urgent_rd)
         sel_cmd = CMD_RD;
      else if (rd_req_i && wr_req_i)
         sel_cmd = rr_rd ? CMD_RD : CMD_WR;
      else if (rd_req_i)
         sel_cmd = CMD_RD;
      else if (wr_req_i)
         sel_cmd = CMD_WR;
      else if (debt != '0)
         sel_cmd = CMD_REF;
      else
         sel_valid = 1'b0;

      case (sel_cmd)
         CMD_RD:  sel_addr = rd_addr_i;
         CMD_WR:  sel_addr = wr_addr_i;
         default: sel_addr = '0;
      endcase
   end

   always_ff @(posedge DRAM_CLK_i or posedge DRAM_RST_i) begin
      if (DRAM_RST_i) begin
         state          <= ST_IDLE;
         tick_cnt       <= '0;
         debt           <= '0;
         rr_rd          <= 1'b1;
         ctrl_valid_o   <= 1'b0;
         ctrl_cmd_o     <= CMD_RD;
         ctrl_addr_o    <= '0;
         rd_gnt_o       <= 1'b0;
         wr_gnt_o       <= 1'b0;
         rd_done_o      <= 1'b0;
         wr_done_o      <= 1'b0;
         ref_overflow_o <= 1'b0;
      end else begin
         tick_cnt  <= tick_wrap ? '0 : tick_cnt + TICK_W'(1);
         debt      <= debt_nxt;
         if (debt_nxt == DEBT_W'(REF_MAX))
            ref_overflow_o <= 1'b1;
         rd_gnt_o  <= 1'b0;
         wr_gnt_o  <= 1'b0;
         rd_done_o <= 1'b0;
         wr_done_o <= 1'b0;

         case (state)
            ST_IDLE: begin
               if (sel_valid) begin
                  ctrl_valid_o <= 1'b1;
                  ctrl_cmd_o   <= sel_cmd;
                  ctrl_addr_o  <= sel_addr;
                  state        <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               if (ctrl_ready_i) begin
                  ctrl_valid_o <= 1'b0;
                  rd_gnt_o     <= (ctrl_cmd_o == CMD_RD);
                  wr_gnt_o     <= (ctrl_cmd_o == CMD_WR);
                  if (ctrl_cmd_o != CMD_REF)
                     rr_rd <= (ctrl_cmd_o == CMD_WR);
                  state        <= ST_BUSY;
               end
            end
            ST_BUSY: begin
               // cmd stays registered through BUSY so done can be routed
               if (ctrl_done_i) begin
                  rd_done_o <= (ctrl_cmd_o == CMD_RD);
                  wr_done_o <= (ctrl_cmd_o == CMD_WR);
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
